adc_spi_sampler: RTL and testbench

- SPI master for the MCP3204 ADC on the MIKROE-340 board: runs one single-ended or differential conversion per request and returns the 12-bit result with a one-cycle valid strobe.
- Sits directly upstream of the sample-collection stage; sample/sample_valid replace the free-running counter tap, so the collector gets an explicit handshake.

---
 rtl/adc_pkg.sv | 28 ++
 rtl/spi_clk_div.sv | 25 ++
 rtl/adc_spi_sampler.sv | 135 +++++++++++++
 tb/tb_adc_spi_sampler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and frame constants for the MCP3204 SPI sampler.
// Used by adc_spi_sampler (optional build macro: ADC_SCAN_EN).
package adc_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, HOLD} state_t;

  localparam int ADC_BITS       = 12;
  localparam int FRAME_BITS     = 19;
  localparam int FIRST_DATA_BIT = 8;
  localparam int CMD_BITS       = 5;

  // Command bit n (1-based): start, SGL/DIFF, D2=0, D1, D0; zero afterwards.
  function automatic logic cmd_bit(input logic [4:0] n, input logic sgl,
                                   input logic [1:0] ch);
    logic b;
    case (n)
      5'd1:    b = 1'b1;
      5'd2:    b = sgl;
      5'd3:    b = 1'b0;
      5'd4:    b = ch[1];
      5'd5:    b = ch[0];
      default: b = 1'b0;
    endcase
    if (n > 5'(CMD_BITS)) b = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: one-clk tick every CLK_DIV clks while en is high.
// Held cleared whenever en is low, so each frame starts from a fresh count.
module spi_clk_div #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             cnt <= '0;
    else if (!en || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/adc_spi_sampler.sv
// SPI master for the MCP3204: one 19-bit frame per accepted start, 12-bit result out.
// Build macro ADC_SCAN_EN: ignore channel input and scan channels 0,1,2,3,0...
module adc_spi_sampler
  import adc_pkg::*;
#(
  parameter int   CLK_DIV = 250,
  parameter int   CS_IDLE = 50,
  parameter logic SGL     = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          channel,
  output logic                busy,
  output logic                cs_n,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output logic [ADC_BITS-1:0] sample,
  output logic [1:0]          sample_ch,
  output logic                sample_valid
);

  localparam logic [4:0] FIRST_BIT = 5'(FIRST_DATA_BIT);
  localparam logic [4:0] LAST_BIT  = 5'(FRAME_BITS);
  localparam logic [9:0] HOLD_LAST = 10'(CS_IDLE - 1);

  state_t              state;
  logic                tick;
  logic                div_en;
  logic [4:0]          bit_cnt;
  logic [4:0]          bit_nxt;
  logic [9:0]          hold_cnt;
  logic [1:0]          ch_q;
  logic                cap_p;
  logic                miso_p0;
  logic                miso_p1;
  logic [ADC_BITS-1:0] sr;

  assign div_en  = (state == SETUP) || (state == SHIFT);
  assign bit_nxt = bit_cnt + 5'd1;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .tick (tick)
  );

`ifdef ADC_SCAN_EN
  logic unused_channel;
  assign unused_channel = ^channel;
`endif

  // miso synchroniser (p0, p1); capture happens the clk after each sclk rise
  // so that two sync flops fit even at the smallest divider.
  always_ff @(posedge clk) begin
    {miso_p1, miso_p0} <= {miso_p0, miso};
    if (cap_p) sr <= {sr[ADC_BITS-2:0], miso_p1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      cs_n         <= 1'b1;
      sclk         <= 1'b0;
      mosi         <= 1'b0;
      bit_cnt      <= '0;
      hold_cnt     <= '0;
      ch_q         <= '0;
      cap_p        <= 1'b0;
      sample       <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      cap_p        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            sclk    <= 1'b0;
            mosi    <= 1'b1;
            bit_cnt <= '0;
`ifndef ADC_SCAN_EN
            ch_q    <= channel;
`endif
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (tick) state <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            sclk <= ~sclk;
            if (!sclk) begin
              bit_cnt <= bit_nxt;
              cap_p   <= (bit_nxt >= FIRST_BIT);
            end else if (bit_cnt == LAST_BIT) begin
              cs_n  <= 1'b1;
              mosi  <= 1'b0;
              state <= DONE;
            end else begin
              mosi <= cmd_bit(bit_nxt, SGL, ch_q);
            end
          end
        end
        DONE: begin
          sample       <= sr;
          sample_ch    <= ch_q;
          sample_valid <= 1'b1;
          hold_cnt     <= '0;
`ifdef ADC_SCAN_EN
          ch_q         <= ch_q + 2'd1;
`endif
          state        <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            busy     <= 1'b0;
            hold_cnt <= '0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 10'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Scoreboard bench for adc_spi_sampler: a default instance (directed frames) and a
// fast instance (CLK_DIV=2, CS_IDLE=1) driven with random start/channel/data.
module tb_adc_spi_sampler;

  localparam logic SGL = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  start = 2'b00;
  logic [1:0]  miso = 2'b00;
  logic [1:0]  busy, cs_n, sclk, mosi, sample_valid;
  logic [1:0]  channel   [2];
  logic [11:0] adc_data  [2];
  logic [11:0] sample    [2];
  logic [1:0]  sample_ch [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [11:0] data;
    int          t;
  } frame_t;

  frame_t      fifo [2][8];
  int          wr [2];
  int          rd [2];
  int          rises [2];
  int          last_rise [2];
  int          per [2];
  int          cs_hi [2];
  logic [18:0] bits [2];
  logic        prev_sclk [2];
  logic        prev_cs [2];
  logic        seen [2];
  logic [1:0]  scan [2];

  function automatic int div_of(input int i);
    return (i == 0) ? 250 : 2;
  endfunction

  function automatic int csi_of(input int i);
    return (i == 0) ? 50 : 1;
  endfunction

  adc_spi_sampler u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .channel(channel[0]),
    .busy(busy[0]), .cs_n(cs_n[0]), .sclk(sclk[0]), .mosi(mosi[0]),
    .miso(miso[0]), .sample(sample[0]), .sample_ch(sample_ch[0]),
    .sample_valid(sample_valid[0])
  );

  adc_spi_sampler #(.CLK_DIV(2), .CS_IDLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .channel(channel[1]),
    .busy(busy[1]), .cs_n(cs_n[1]), .sclk(sclk[1]), .mosi(mosi[1]),
    .miso(miso[1]), .sample(sample[1]), .sample_ch(sample_ch[1]),
    .sample_valid(sample_valid[1])
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, i, act, exp);
    end
  endtask

  // ADC model, frame checker and scoreboard, sampled on the falling clk edge.
  always @(negedge clk) begin
    frame_t e;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        wr[i] = 0; rd[i] = 0; rises[i] = 0; seen[i] = 1'b0; cs_hi[i] = 0;
        scan[i] = 2'd0; miso[i] = 1'b0; per[i] = 2 * div_of(i); bits[i] = '0;
        last_rise[i] = 0;
      end else begin
        if (prev_cs[i] && !cs_n[i]) begin
          check("frame_requested", i, 32'(wr[i] != rd[i]), 32'd1);
          if (seen[i]) check("cs_high_gap", i, 32'(cs_hi[i] >= csi_of(i)), 32'd1);
          rises[i] = 0; bits[i] = '0; per[i] = 2 * div_of(i); last_rise[i] = cyc;
        end
        if (!cs_n[i] || !prev_cs[i]) begin
          if (!prev_sclk[i] && sclk[i]) begin
            if (rises[i] > 0 && cyc - last_rise[i] != 2 * div_of(i))
              per[i] = cyc - last_rise[i];
            last_rise[i] = cyc;
            rises[i]++;
            bits[i] = {bits[i][17:0], mosi[i]};
          end
          if (prev_sclk[i] && !sclk[i]) begin
            if (rises[i] >= 7 && rises[i] <= 18 && wr[i] != rd[i]) begin
              e = fifo[i][rd[i] % 8];
              miso[i] = e.data[18 - rises[i]];
            end else begin
              miso[i] = 1'($urandom);
            end
          end
        end
        if (!prev_cs[i] && cs_n[i]) begin
          seen[i] = 1'b1;
          cs_hi[i] = 0;
          e = fifo[i][rd[i] % 8];
          check("sclk_rises", i, 32'(rises[i]), 32'd19);
          check("mosi_frame", i, 32'(bits[i]), 32'({1'b1, SGL, 1'b0, e.ch, 14'b0}));
          check("sclk_period", i, 32'(per[i]), 32'(2 * div_of(i)));
          check("sclk_idle", i, 32'(sclk[i]), 32'd0);
        end
        if (cs_n[i]) cs_hi[i]++;
        if (sample_valid[i]) begin
          check("valid_expected", i, 32'(wr[i] != rd[i]), 32'd1);
          if (wr[i] != rd[i]) begin
            e = fifo[i][rd[i] % 8];
            rd[i]++;
            check("sample", i, 32'(sample[i]), 32'(e.data));
            check("sample_ch", i, 32'(sample_ch[i]), 32'(e.ch));
            check("latency", i, 32'(cyc - e.t), 32'(39 * div_of(i) + 1));
          end
        end
        if (start[i] && !busy[i]) begin
`ifdef ADC_SCAN_EN
          fifo[i][wr[i] % 8].ch = scan[i];
          scan[i] = scan[i] + 2'd1;
`else
          fifo[i][wr[i] % 8].ch = channel[i];
`endif
          fifo[i][wr[i] % 8].data = adc_data[i];
          fifo[i][wr[i] % 8].t    = cyc + 1;
          wr[i]++;
        end
      end
      prev_sclk[i] = sclk[i];
      prev_cs[i]   = cs_n[i];
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int i, input int limit);
    int n = 0;
    while ((wr[i] != rd[i] || busy[i]) && n < limit) begin
      step(1);
      n++;
    end
    check("drain", i, 32'((wr[i] != rd[i]) || busy[i]), 32'd0);
  endtask

  task automatic pulse_start(input int i, input logic [1:0] ch, input logic [11:0] d);
    step(1);
    start[i] = 1'b1; channel[i] = ch; adc_data[i] = d;
    step(1);
    start[i] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    for (int i = 0; i < 2; i++)
      check(name, i,
            32'({cs_n[i], sclk[i], mosi[i], busy[i], sample_valid[i], sample[i], sample_ch[i]}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'b00}));
  endtask

  initial begin
    int base, g, n;
    channel[0] = 2'd0; channel[1] = 2'd0;
    adc_data[0] = 12'h0; adc_data[1] = 12'h0;
    step(3);
    rst = 1'b1;
    step(1);
    check_reset_outputs("reset_state");

    // Fast instance: random requests, channels and data every cycle.
    repeat (4000) begin
      step(1);
      start[1]    = ($urandom % 4) == 0;
      channel[1]  = 2'($urandom);
      adc_data[1] = 12'($urandom);
    end
    start[1] = 1'b0;
    wait_idle(1, 200);
    check("random_frames", 1, 32'(wr[1] > 10), 32'd1);

    // Reset in the middle of bit 12 aborts the frame without a sample.
    pulse_start(0, 2'b10, 12'h3C3);
    step(6100);
    check("bit12_reached", 0, 32'(rises[0]), 32'd12);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort_reset");
    step(2);
    rst = 1'b1;

    pulse_start(0, 2'b10, 12'hA5C);
    wait_idle(0, 12000);
    check("a5c_sample", 0, 32'(sample[0]), 32'h0A5C);
`ifndef ADC_SCAN_EN
    check("a5c_channel", 0, 32'(sample_ch[0]), 32'd2);
`endif

    // start held high: back-to-back frames, busy low for one clk between them.
    base = wr[0];
    step(1);
    channel[0] = 2'b01; adc_data[0] = 12'h001; start[0] = 1'b1;
    step(1);
    adc_data[0] = 12'hFFF;
    n = 0;
    while (busy[0] && n < 12000) begin step(1); n++; end
    g = 0;
    while (!busy[0] && g < 10) begin step(1); g++; end
    check("busy_gap", 0, 32'(g), 32'd1);
    start[0] = 1'b0;
    wait_idle(0, 12000);
    check("b2b_frames", 0, 32'(wr[0] - base), 32'd2);
    check("b2b_last", 0, 32'(sample[0]), 32'h0FFF);

    // Mid-frame start and channel change have no effect on the running frame.
    base = wr[0];
    pulse_start(0, 2'b01, 12'($urandom));
    step(3000);
    start[0] = 1'b1; channel[0] = 2'b11;
    step(1);
    start[0] = 1'b0;
    wait_idle(0, 12000);
    check("midframe_frames", 0, 32'(wr[0] - base), 32'd1);
`ifndef ADC_SCAN_EN
    check("midframe_channel", 0, 32'(sample_ch[0]), 32'd1);
`endif
    step(100);
    check("no_extra_frame", 0, 32'({busy[0], cs_n[0]}), 32'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
